// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, the default bit divisor
// (also used by the transmitter) and frame-length constants.
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 25 MHz system clock / 115200 baud
    localparam int UART_DEFAULT_CLKS_PER_BIT = 217;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_e;

    // Even parity: XOR of the data bits and the parity bit must be 0.
    function automatic logic even_parity_ok(input logic [UART_DATA_BITS-1:0] data,
                                            input logic                      par);
        return ~((^data) ^ par);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for an asynchronous single-bit input.
// Parameters:
//   RESET_VAL  value both flops take during reset (idle level of the line)
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   d      in   asynchronous input
//   q      out  synchronised output (2 cycles latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) at a fixed
// divisor of the system clock, delivered through a single-entry holding
// register with a valid/ready handshake. Errors are reported as 1-cycle pulses.
// Configuration macro: UART_RX_PARITY_EN (adds even-parity bit and parity_err).
// Parameters:
//   CLKS_PER_BIT  system clocks per bit, >= 4
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   rxd         in   asynchronous serial input, idle high
//   rx_data     out  received byte, stable while rx_valid is high
//   rx_valid    out  holding register full
//   rx_ready    in   consumer takes the byte on rx_valid && rx_ready
//   frame_err   out  pulse: stop bit sampled low
//   overrun     out  pulse: completed byte dropped (holding register full)
//   parity_err  out  pulse: parity mismatch (constant 0 without parity)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int             DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rxd_s;

    uart_rx_state_e   state_q, state_d;
    logic             armed_q, armed_d;
    logic [1:0]       settle_q, settle_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic div_expired;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign div_expired = (div_q == '0);

    always_comb begin
        state_d     = state_q;
        // The synchronizer resets to 1, so its output shows a fake idle level
        // until real samples have flushed through; settle_q masks that window
        // so a reset released mid-frame cannot arm the start detector.
        settle_d    = {settle_q[0], 1'b1};
        armed_d     = armed_q | (settle_q[1] & rxd_s);
        div_d       = div_expired ? DIV_FULL : (div_q - DIV_ONE);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                div_d     = '0;
                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (armed_q && !rxd_s) begin
                    div_d   = DIV_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (div_expired) begin
                    // Line back high at mid-start: a glitch, not a frame.
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (div_expired) begin
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (div_expired) begin
                    par_bad_d = ~even_parity_ok(shift_q, rxd_s);
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (div_expired) begin
                    // Back to IDLE at mid-stop so zero-gap frames are caught.
                    state_d = ST_IDLE;
                    if (!rxd_s) begin
                        // Require the line to go high again before the next
                        // start, so a held break is reported once.
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            settle_q     <= 2'b00;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            settle_q     <= settle_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Shift register is pure datapath; its contents are only used after a
    // full frame has been shifted in.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Event codes in the observed/expected logs: bytes are 0..255.
    localparam int EV_FE  = 32'h100;
    localparam int EV_PE  = 32'h200;
    localparam int EV_OVR = 32'h300;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int log_q[$];

    // Observe transfers and error pulses away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) log_q.push_back(int'(rx_data));
            if (frame_err)  log_q.push_back(EV_FE);
            if (parity_err) log_q.push_back(EV_PE);
            if (overrun)    log_q.push_back(EV_OVR);
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         pbad;
        int         gap;
        int         exp_ev;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];

    function automatic vec_t mk(logic [7:0] d, bit s, bit p, int g, int e);
        vec_t v;
        v.data = d; v.stop = s; v.pbad = p; v.gap = g; v.exp_ev = e;
        return v;
    endfunction

    // Reference: what one frame should produce, from the frame rules alone.
    function automatic int model_ev(logic [7:0] d, bit stop, bit pbad);
        if (!stop) return EV_FE;
        if (PAR_EN && pbad) return EV_PE;
        return int'(d);
    endfunction

    function automatic int get_ev(int idx);
        if (idx < 0 || idx >= log_q.size()) return -1;
        return log_q[idx];
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(logic [7:0] data, bit stop, bit pbad);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            tick(CPB);
        end
        if (PAR_EN) begin
            rxd = (^data) ^ pbad;
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int lat;

        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        check("reset_rx_valid",   int'(rx_valid),   0);
        check("reset_rx_data",    int'(rx_data),    0);
        check("reset_frame_err",  int'(frame_err),  0);
        check("reset_overrun",    int'(overrun),    0);
        check("reset_parity_err", int'(parity_err), 0);
        reset = 1'b0;
        tick(4 * CPB);

        // ---- latency of one frame, edge drive to rx_valid ----
        mark = log_q.size();
        lat  = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (!rx_valid && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        rxd = 1'b1;
        tick(2 * CPB);
        check("latency_window", int'(lat >= 79 + (PAR_EN ? 8 : 0) && lat <= 81 + (PAR_EN ? 8 : 0)), 1);
        check("latency_byte",  get_ev(mark), 32'hA5);
        check("latency_count", log_q.size() - mark, 1);

        // ---- table-driven frames ----
        vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 1, 32'hA5));
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 0, 32'h00));
        vecs.push_back(mk(8'hFF, 1'b1, 1'b0, 1, 32'hFF));
        vecs.push_back(mk(8'h3C, 1'b0, 1'b0, 2, EV_FE));
        vecs.push_back(mk(8'h11, 1'b1, 1'b0, 1, 32'h11));
        vecs.push_back(mk(8'h80, 1'b1, 1'b0, 0, 32'h80));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1, 32'h01));
        if (PAR_EN) begin
            vecs.push_back(mk(8'h07, 1'b1, 1'b1, 1, EV_PE));
            vecs.push_back(mk(8'h07, 1'b1, 1'b0, 1, 32'h07));
        end
        mark = log_q.size();
        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pbad);
            rxd = 1'b1;
            tick(vecs[i].gap * CPB);
        end
        tick(2 * CPB);
        check("table_count", log_q.size() - mark, vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("table_vec%0d", i), get_ev(mark + i), vecs[i].exp_ev);
        end

        // ---- glitch on idle line ----
        mark = log_q.size();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(4 * CPB);
        check("glitch_no_event", log_q.size() - mark, 0);
        send_frame(8'h6E, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        check("glitch_then_byte", get_ev(mark), 32'h6E);

        // ---- framing error followed by a long break ----
        mark = log_q.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(30 * CPB);
        check("break_events", log_q.size() - mark, 1);
        check("break_frame_err", get_ev(mark), EV_FE);
        rxd = 1'b1;
        tick(2 * CPB);
        send_frame(8'h11, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        check("break_recover", get_ev(mark + 1), 32'h11);

        // ---- overrun with consumer stalled ----
        rx_ready = 1'b0;
        mark = log_q.size();
        send_frame(8'h12, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(CPB);
        send_frame(8'h34, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        check("ovr_valid_held", int'(rx_valid), 1);
        check("ovr_data_kept",  int'(rx_data), 32'h12);
        check("ovr_events",     log_q.size() - mark, 1);
        check("ovr_pulse",      get_ev(mark), EV_OVR);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_drain_valid", int'(rx_valid), 0);
        check("ovr_drain_byte",  get_ev(mark + 1), 32'h12);
        tick(2 * CPB);
        check("ovr_drain_count", log_q.size() - mark, 2);

        // ---- reset in the middle of data bit 3, line low on release ----
        mark = log_q.size();
        rxd = 1'b0;
        tick(CPB);
        tick(3 * CPB);
        tick(CPB / 2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(12 * CPB);
        check("rst_mid_no_event", log_q.size() - mark, 0);
        check("rst_mid_no_valid", int'(rx_valid), 0);
        rxd = 1'b1;
        tick(2 * CPB);
        send_frame(8'h5A, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        check("rst_mid_count", log_q.size() - mark, 1);
        check("rst_mid_byte",  get_ev(mark), 32'h5A);

        // ---- randomized frames against the reference model ----
        mark = log_q.size();
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            int         r;
            bit         s;
            bit         p;
            int         g;
            d = 8'($urandom);
            r = int'($urandom_range(0, 7));
            s = (r != 0);
            p = PAR_EN && (r == 1);
            g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            exp_q.push_back(model_ev(d, s, p));
            send_frame(d, s, p);
            rxd = 1'b1;
            tick(g * CPB);
        end
        tick(2 * CPB);
        check("rand_count", log_q.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_frame%0d", i), get_ev(mark + i), exp_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
